mul_sequencer: RTL and testbench

//  Issue/retire stage in front of the 32-cycle Multiplier (mul/stall/A/B/mulRes).
//  - Accepts operand requests over a valid/ready handshake.
//  - Drives the Multiplier's mul, A and B, and tracks its step sequence via stall.
//  - Captures the 64-bit product and applies the unsigned correction when requested.
//  - Holds the result in a 1-entry output buffer until the consumer takes it.

---
 rtl/mul_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mul_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sequencer
//  Description : Issue/retire stage in front of the 32-cycle Multiplier.
//                Accepts operand requests on a valid/ready handshake, drives
//                the Multiplier (mul, A, B), follows its step sequence via
//                stall, captures the 64-bit product (with unsigned correction
//                when requested) and holds it in a 1-entry output buffer.
//  Ports       :
//    CLK          clock, rising edge
//    rst          asynchronous reset, active-high
//    req_valid/req_ready/req_a/req_b/req_signed   operand request channel
//    res_valid/res_ready/res_prod                 product result channel
//    busy         state is not IDLE
//    err          sticky timeout flag, cleared only by rst
//    mul, mA, mB  to Multiplier
//    stall, mulRes from Multiplier
//  Revision    : 1.0  initial release
// ============================================================================
module mul_sequencer #(
    parameter int TIMEOUT = 40
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_signed,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_prod,
    output logic        busy,
    output logic        err,
    output logic        mul,
    output logic [31:0] mA,
    output logic [31:0] mB,
    input  logic        stall,
    input  logic [63:0] mulRes
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q,     state_d;
    logic               mul_q,       mul_d;
    logic [31:0]        mA_q,        mA_d;
    logic [31:0]        mB_q,        mB_d;
    logic               sgn_q,       sgn_d;
    logic               res_valid_q, res_valid_d;
    logic [63:0]        res_prod_q,  res_prod_d;
    logic               err_q,       err_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;

    logic [31:0]        corr_hi;
    logic               step_done;
    logic               cnt_expired;

    // Signed product from the Multiplier is turned into the unsigned product
    // by adding back B*2^32 when A is negative-as-signed and vice versa.
    assign corr_hi = mulRes[63:32]
                   + (mA_q[31] ? mB_q : 32'd0)
                   + (mB_q[31] ? mA_q : 32'd0);

    assign step_done   = (state_q == ST_FLUSH || state_q == ST_RUN) && !stall;
    assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        mul_d       = mul_q;
        mA_d        = mA_q;
        mB_d        = mB_q;
        sgn_d       = sgn_q;
        res_valid_d = res_valid_q;
        res_prod_d  = res_prod_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_FLUSH: begin
                mul_d = 1'b1;
                mA_d  = 32'd0;
                mB_d  = 32'd0;
                // mul_q must already be high: stall is meaningless while the
                // Multiplier is not being driven right after reset.
                if (mul_q && !stall) begin
                    state_d = ST_IDLE;
                    mul_d   = 1'b0;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    mul_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                mul_d = 1'b0;
                if (req_valid) begin
                    mA_d    = req_a;
                    mB_d    = req_b;
                    sgn_d   = req_signed;
                    mul_d   = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                mul_d   = 1'b1;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                mul_d = 1'b1;
                if (!stall) begin
                    res_prod_d  = sgn_q ? mulRes : {corr_hi, mulRes[31:0]};
                    res_valid_d = 1'b1;
                    mul_d       = 1'b0;
                    state_d     = ST_DONE;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    mul_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                mul_d = 1'b0;
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                mul_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            mul_q       <= 1'b0;
            mA_q        <= 32'd0;
            mB_q        <= 32'd0;
            sgn_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_prod_q  <= 64'd0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mul_q       <= mul_d;
            mA_q        <= mA_d;
            mB_q        <= mB_d;
            sgn_q       <= sgn_d;
            res_valid_q <= res_valid_d;
            res_prod_q  <= res_prod_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // mul is dropped in the very cycle stall falls: with mul high at S==32 the
    // Multiplier would wrap S to 0, so gating it here parks S at 32 for IDLE.
    assign mul       = mul_q && !step_done;
    assign mA        = mA_q;
    assign mB        = mB_q;
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = res_valid_q;
    assign res_prod  = res_prod_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_sequencer
//  Description : Self-checking bench for mul_sequencer with a behavioural
//                Multiplier model and an arithmetic product reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_sequencer;

    logic        CLK = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_signed;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_prod;
    logic        busy;
    logic        err;
    logic        mul;
    logic [31:0] mA;
    logic [31:0] mB;
    logic        stall;
    logic [63:0] mulRes;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    mul_sequencer #(.TIMEOUT(40)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_signed(req_signed),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_prod  (res_prod),
        .busy      (busy),
        .err       (err),
        .mul       (mul),
        .mA        (mA),
        .mB        (mB),
        .stall     (stall),
        .mulRes    (mulRes)
    );

    // ---------------- Multiplier model (no reset on S) ----------------
    logic [5:0]  S;
    logic        seed_en = 1'b0;
    logic [5:0]  seed_val = 6'd0;
    logic        force_stall = 1'b0;
    logic [63:0] full_prod;

    always @(posedge CLK) begin
        if (seed_en)  S <= seed_val;
        else if (mul) S <= (S < 6'd32) ? S + 6'd1 : 6'd0;
    end

    assign stall     = force_stall | (S < 6'd32);
    assign full_prod = {{32{mA[31]}}, mA} * {{32{mB[31]}}, mB};
    // Garbage until the sequence completes, so capture timing matters.
    assign mulRes    = (S == 6'd32) ? full_prod : (full_prod ^ {32'hDEADBEEF, 26'd0, S});

    // ---------------- Reference: plain arithmetic product ----------------
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    task automatic wait_ready(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: req_ready got 0 after 60 cycles, required 1", name);
        end
    endtask

    // Issue one request; returns accept edge number.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int t_acc);
        req_a = a; req_b = b; req_signed = s; req_valid = 1'b1;
        @(posedge CLK); #1;
        t_acc = cyc;
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_signed = 1'($urandom);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold);
        bit          ok;
        int          t_acc;
        logic [63:0] exp_p;
        bit          seen;
        exp_p = ref_prod(a, b, s);
        res_ready = 1'b0;
        wait_ready(name, ok);
        if (!ok) return;
        issue(a, b, s, t_acc);
        checks++;
        if (mA !== a || mB !== b || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_latch: mA=%h mB=%h busy=%b, required %h %h 1", name, mA, mB, busy, a, b);
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #1;
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || (cyc - t_acc) != 34) begin
            errors++;
            $display("FAIL %s_latency: res_valid seen=%0d after %0d edges, required 34", name, seen, cyc - t_acc);
            return;
        end
        checks++;
        if (res_prod !== exp_p) begin
            errors++;
            $display("FAIL %s_prod: got %h, required %h", name, res_prod, exp_p);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (res_valid !== 1'b1 || res_prod !== exp_p || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold: valid=%b prod=%h ready=%b, required 1 %h 0",
                         name, res_valid, res_prod, req_ready, exp_p);
            end
        end
        res_ready = 1'b1;
        @(posedge CLK); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || mul !== 1'b0) begin
            errors++;
            $display("FAIL %s_handshake: valid=%b ready=%b mul=%b, required 0 1 0",
                     name, res_valid, req_ready, mul);
        end
    endtask

    task automatic do_reset(input string name);
        bit ok;
        int n;
        rst = 1'b1;
        seed_en = 1'b1;
        seed_val = 6'($urandom_range(0, 32));
        @(posedge CLK); #1;
        seed_en = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0 || err !== 1'b0 ||
            mul !== 1'b0 || mA !== 32'd0 || mB !== 32'd0 || res_prod !== 64'd0) begin
            errors++;
            $display("FAIL %s_values: ready=%b busy=%b valid=%b err=%b mul=%b mA=%h prod=%h, required 0 1 0 0 0 0 0",
                     name, req_ready, busy, res_valid, err, mul, mA, res_prod);
        end
        @(negedge CLK);
        rst = 1'b0;
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            n++;
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || n > 35 || S !== 6'd32) begin
            errors++;
            $display("FAIL %s_flush: ready=%b after %0d cycles S=%0d, required 1 within 35 and S=32",
                     name, ok, n, S);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_directed();
        run_op("u7x6",      32'd7,          32'd6,          1'b0, 0);
        run_op("s_m3x5",    32'hFFFF_FFFD,  32'h5,          1'b1, 0);
        run_op("u_max",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 0);
        run_op("s_minmin",  32'h8000_0000,  32'h8000_0000,  1'b1, 0);
        run_op("u_minmax",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1);
    endtask

    task automatic test_backpressure();
        run_op("bp", $urandom, $urandom, 1'b0, 10);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++)
            run_op("rand", $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    endtask

    task automatic test_ignore();
        bit          ok;
        int          t_acc;
        logic [31:0] a;
        a = $urandom;
        wait_ready("ignore", ok);
        if (!ok) return;
        issue(a, 32'd3, 1'b0, t_acc);
        req_valid = 1'b1;
        req_a = ~a;
        repeat (5) @(posedge CLK);
        #1;
        req_valid = 1'b0;
        checks++;
        if (mA !== a || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignore: mA=%h ready=%b, required %h 0", mA, req_ready, a);
        end
        // Drain the in-flight result.
        repeat (40) begin
            @(posedge CLK); #1;
            if (res_valid) break;
        end
        res_ready = 1'b1;
        @(posedge CLK); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t_acc;
        wait_ready("rst_mid", ok);
        if (!ok) return;
        issue($urandom, $urandom, 1'b0, t_acc);
        repeat (16) @(posedge CLK);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1 || mul !== 1'b0 || mA !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b ready=%b busy=%b mul=%b mA=%h, required 0 0 1 0 0",
                     res_valid, req_ready, busy, mul, mA);
        end
        @(negedge CLK);
        rst = 1'b0;
        run_op("after_rst", $urandom, $urandom, 1'($urandom), 0);
    endtask

    task automatic test_timeout();
        bit ok;
        int t_acc;
        bit seen;
        wait_ready("timeout", ok);
        if (!ok) return;
        issue($urandom, $urandom, 1'b0, t_acc);
        force_stall = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || (cyc - t_acc) != 41 || req_ready !== 1'b1 || res_valid !== 1'b0 || mul !== 1'b0) begin
            errors++;
            $display("FAIL timeout: err=%b at %0d edges ready=%b valid=%b mul=%b, required 1 at 41, 1 0 0",
                     seen, cyc - t_acc, req_ready, res_valid, mul);
        end
        force_stall = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b, required 1", err);
        end
        do_reset("reset_clear");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b, required 0", err);
        end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0;
        req_a = 32'd0;
        req_b = 32'd0;
        req_signed = 1'b0;
        res_ready = 1'b0;
        #2;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_ignore();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
